// File: rtl/board_line_fetch.sv
// -----------------------------------------------------------------------------
// board_line_fetch
//
// Purpose:
//   Prefetches the board row for the next scanline during horizontal blanking.
//   It makes one read request to a shared memory arbiter and places the
//   returned word in a shadow register. At the last pixel of the line the
//   shadow word is copied to currLine, so the pixel pipeline always sees a row
//   that stays constant for the whole scanline. A fetch that is still
//   outstanding at line end is aborted. In that case currLine is blanked and
//   fetch_miss pulses for one cycle.
//
//   The board covers 20 rows of 24 scanlines each, which is scanlines 0..479.
//   During vertical blanking no memory request is made. The shadow register is
//   simply zero-filled instead.
//
// Compile-time option:
//   BOARD_ROW_GAP_EN - when defined, the line swap loads 16'h0000 on the last
//                      scanline of every block row. This draws a one-scanline
//                      black gap between rows. The memory fetch still happens.
//
// Parameters:
//   BOARD_BASE - word address of board row 0
//   FETCH_H    - hcount that starts the next-line fetch (in horizontal blanking)
//   H_LAST     - last hcount of a line; the line swap happens here
//   V_LAST     - last vcount of a frame
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous active-high reset
//   hcount     in  10   current pixel column
//   vcount     in  10   current scanline
//   mem_gnt    in   1   arbiter grant for mem_req
//   mem_data   in  16   read data, valid the cycle after the grant cycle
//   mem_req    out  1   memory read request
//   mem_addr   out 16   read word address
//   currLine   out 16   board row for the current scanline (bits 9:0 = cols 0..9)
//   fetch_miss out  1   one-cycle pulse when a fetch missed the line end
// -----------------------------------------------------------------------------
module board_line_fetch #(
  parameter logic [15:0] BOARD_BASE = 16'h0100,
  parameter logic [9:0]  FETCH_H    = 10'd650,
  parameter logic [9:0]  H_LAST     = 10'd799,
  parameter logic [9:0]  V_LAST     = 10'd524
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        mem_gnt,
  input  logic [15:0] mem_data,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [15:0] currLine,
  output logic        fetch_miss
);

  localparam logic [9:0] ROW_LINES    = 10'd24;
  localparam logic [9:0] ACTIVE_LINES = 10'd480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // ---------------------------------------------------------------------------
  // Next-scanline geometry
  // ---------------------------------------------------------------------------
  logic [9:0] next_v;
  logic [9:0] row;
  logic       visible;
  logic       trigger;
  logic       line_end;
  logic       row_gap;

  assign next_v   = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
  // The divisor is a constant, so this becomes a small fixed divider.
  assign row      = next_v / ROW_LINES;
  assign visible  = next_v < ACTIVE_LINES;
  assign trigger  = hcount == FETCH_H;
  assign line_end = hcount == H_LAST;

`ifdef BOARD_ROW_GAP_EN
  // The last scanline of each 24-line block row is shown black.
  assign row_gap = (next_v % ROW_LINES) == (ROW_LINES - 10'd1);
`else
  assign row_gap = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM control
  // ---------------------------------------------------------------------------
  logic fetch_start;   // latch the address and start requesting
  logic blank_fill;    // vertical blanking: zero-fill the shadow without a fetch
  logic capture;       // read data is on mem_data this cycle
  logic abort;         // line ended with a fetch still in flight

  // NOTE: every signal assigned in this block gets a default value first.
  // Otherwise a path that does not assign it would infer a latch.
  always_comb begin
    state_next  = state;
    fetch_start = 1'b0;
    blank_fill  = 1'b0;
    capture     = 1'b0;
    abort       = 1'b0;
    mem_req     = 1'b0;

    unique case (state)
      IDLE: begin
        // A trigger can only be accepted here. The REQ and DATA states do not
        // look at it, so a trigger that arrives mid-fetch is dropped. The swap
        // takes priority if the two hcounts were ever configured to coincide.
        if (trigger && !line_end) begin
          if (visible) begin
            fetch_start = 1'b1;
            state_next  = REQ;
          end else begin
            blank_fill  = 1'b1;
          end
        end
      end

      REQ: begin
        mem_req = 1'b1;
        if (line_end) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (mem_gnt) begin
          state_next = DATA;
        end
      end

      DATA: begin
        if (line_end) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else begin
          capture    = 1'b1;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples values from before the clock edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: address, shadow register, line swap and miss pulse
  // ---------------------------------------------------------------------------
  logic [15:0] shadow;
  logic        shadow_ok;
  logic [15:0] swap_value;

  // An abort, an empty shadow and a gap line all display as a blank row.
  assign swap_value = (shadow_ok && !row_gap && !abort) ? shadow : 16'h0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr   <= 16'h0000;
      shadow     <= 16'h0000;
      shadow_ok  <= 1'b0;
      currLine   <= 16'h0000;
      fetch_miss <= 1'b0;
    end else begin
      // This is high only for the cycle after an abort, so it forms a
      // one-cycle pulse.
      fetch_miss <= abort;

      // The address wraps modulo 2^16. It is held through REQ and keeps its
      // value until the next fetch starts.
      if (fetch_start) begin
        mem_addr <= BOARD_BASE + {6'd0, row};
      end

      if (capture) begin
        shadow    <= mem_data;
        shadow_ok <= 1'b1;
      end

      if (blank_fill) begin
        shadow    <= 16'h0000;
        shadow_ok <= 1'b1;
      end

      // capture and blank_fill never happen on the line_end cycle. That makes
      // this clear of shadow_ok unambiguous.
      if (line_end) begin
        currLine  <= swap_value;
        shadow_ok <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_board_line_fetch.sv
// -----------------------------------------------------------------------------
// tb_board_line_fetch
//
// Directed testbench for board_line_fetch. The bench drives hcount and vcount
// directly. It models the memory and the arbiter: each grant returns the word
// at mem_addr on the following cycle. A second instance with BOARD_BASE near
// the top of memory checks that the address addition wraps.
// -----------------------------------------------------------------------------
module tb_board_line_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        mem_gnt;
  logic [15:0] mem_data;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] currLine;
  logic        fetch_miss;

  // Wrap-check instance: its grant is never given, so only its address is used.
  logic        w_gnt  = 1'b0;
  logic [15:0] w_data = 16'h0000;
  logic        w_req;
  logic [15:0] w_addr;
  logic [15:0] w_line;
  logic        w_miss;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model, indexed by the low byte of the word address.
  logic [15:0] mem [256];
  int          gnt_delay;  // grant after this many request cycles; -1 = never
  int          req_cnt;

  // Per-line observations filled in by run_line.
  int          req_cycles;
  logic [15:0] first_addr;
  int          miss_cycles;
  logic        req_after_last;
  logic        cl_changed;

  board_line_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .mem_gnt    (mem_gnt),
    .mem_data   (mem_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .currLine   (currLine),
    .fetch_miss (fetch_miss)
  );

  board_line_fetch #(.BOARD_BASE(16'hFFFA)) dut_w (
    .clk        (clk),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .mem_gnt    (w_gnt),
    .mem_data   (w_data),
    .mem_req    (w_req),
    .mem_addr   (w_addr),
    .currLine   (w_line),
    .fetch_miss (w_miss)
  );

  always #5 clk = ~clk;

  // Expected currLine after a successful fetch for scanline v with data d.
  function automatic logic [15:0] exp_line(int v, logic [15:0] d);
    int nv;
    nv = (v == 524) ? 0 : v + 1;
    if (nv >= 480) return 16'h0000;
`ifdef BOARD_ROW_GAP_EN
    if (nv % 24 == 23) return 16'h0000;
`endif
    return d;
  endfunction

  // One clock cycle. It applies the arbiter grant, advances the clock, and
  // returns read data for a grant from the previous cycle. Outputs are
  // sampled 1 time unit after the edge.
  task automatic tick();
    logic        g;
    logic [15:0] a;
    if (mem_req) begin
      mem_gnt = (gnt_delay >= 0) && (req_cnt >= gnt_delay);
      req_cnt++;
    end else begin
      mem_gnt = 1'b0;
      req_cnt = 0;
    end
    g = mem_req && mem_gnt;
    a = mem_addr;
    @(posedge clk);
    #1;
    mem_data = g ? mem[a[7:0]] : 16'hBEEF;
  endtask

  // Runs scanline v from hcount 640 through 799, then hcount 0 and 1.
  task automatic run_line(int v);
    logic [15:0] cl_start;
    vcount         = 10'(v);
    req_cycles     = 0;
    first_addr     = 16'hxxxx;
    miss_cycles    = 0;
    req_after_last = 1'b0;
    cl_changed     = 1'b0;
    cl_start       = currLine;
    for (int h = 640; h <= 801; h++) begin
      hcount = (h <= 799) ? 10'(h) : 10'(h - 800);
      tick();
      if (mem_req) begin
        if (req_cycles == 0) first_addr = mem_addr;
        req_cycles++;
      end
      if (fetch_miss) miss_cycles++;
      if (h == 799) req_after_last = mem_req;
      if (h < 799 && currLine !== cl_start) cl_changed = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++; if (currLine !== 16'h0000) begin n_bad++; $display("FAIL reset_currLine got=%h exp=0000", currLine); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    n_cmp++; if (mem_addr !== 16'h0000) begin n_bad++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
    n_cmp++; if (fetch_miss !== 1'b0) begin n_bad++; $display("FAIL reset_fetch_miss got=%b exp=0", fetch_miss); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch_basic();
    gnt_delay = 0;
    run_line(47);
    n_cmp++; if (req_cycles !== 1) begin n_bad++; $display("FAIL basic_req_cycles got=%0d exp=1", req_cycles); end
    n_cmp++; if (first_addr !== 16'h0102) begin n_bad++; $display("FAIL basic_addr got=%h exp=0102", first_addr); end
    n_cmp++; if (currLine !== 16'h03F1) begin n_bad++; $display("FAIL basic_currLine got=%h exp=03F1", currLine); end
    n_cmp++; if (miss_cycles !== 0) begin n_bad++; $display("FAIL basic_miss got=%0d exp=0", miss_cycles); end
    n_cmp++; if (cl_changed !== 1'b0) begin n_bad++; $display("FAIL basic_early_change got=%b exp=0", cl_changed); end
  endtask

  task automatic test_rows();
    // Each entry is {vcount, expected address, word stored at that address}.
    int          tv [5] = '{0, 22, 23, 478, 239};
    logic [15:0] ta [5] = '{16'h0100, 16'h0100, 16'h0101, 16'h0113, 16'h010A};
    logic [15:0] td [5] = '{16'h03FF, 16'h03FF, 16'h5A01, 16'h5A13, 16'h5A0A};
    gnt_delay = 0;
    for (int i = 0; i < 5; i++) begin
      run_line(tv[i]);
      n_cmp++; if (first_addr !== ta[i]) begin n_bad++; $display("FAIL row_addr v=%0d got=%h exp=%h", tv[i], first_addr, ta[i]); end
      n_cmp++; if (currLine !== exp_line(tv[i], td[i])) begin n_bad++; $display("FAIL row_currLine v=%0d got=%h exp=%h", tv[i], currLine, exp_line(tv[i], td[i])); end
    end
    // Line 239 also ran in dut_w: FFFA + row 10 wraps to 0004.
    n_cmp++; if (w_addr !== 16'h0004) begin n_bad++; $display("FAIL wrap_addr got=%h exp=0004", w_addr); end
  endtask

  task automatic test_blank();
    int tv [3] = '{479, 500, 523};
    gnt_delay = 0;
    for (int i = 0; i < 3; i++) begin
      run_line(tv[i]);
      n_cmp++; if (req_cycles !== 0) begin n_bad++; $display("FAIL blank_req v=%0d got=%0d exp=0", tv[i], req_cycles); end
      n_cmp++; if (currLine !== 16'h0000) begin n_bad++; $display("FAIL blank_currLine v=%0d got=%h exp=0000", tv[i], currLine); end
    end
    run_line(524);
    n_cmp++; if (first_addr !== 16'h0100) begin n_bad++; $display("FAIL vlast_addr got=%h exp=0100", first_addr); end
    n_cmp++; if (currLine !== 16'h03FF) begin n_bad++; $display("FAIL vlast_currLine got=%h exp=03FF", currLine); end
  endtask

  task automatic test_miss();
    gnt_delay = -1;
    run_line(47);
    n_cmp++; if (currLine !== 16'h0000) begin n_bad++; $display("FAIL miss_currLine got=%h exp=0000", currLine); end
    n_cmp++; if (miss_cycles !== 1) begin n_bad++; $display("FAIL miss_pulse_cycles got=%0d exp=1", miss_cycles); end
    n_cmp++; if (req_after_last !== 1'b0) begin n_bad++; $display("FAIL miss_req_drop got=%b exp=0", req_after_last); end
  endtask

  task automatic test_ignore_trigger();
    gnt_delay = -1;
    vcount = 10'd47;
    hcount = 10'd650;
    repeat (2) tick();
    vcount = 10'd95;
    repeat (2) tick();
    n_cmp++; if (mem_addr !== 16'h0102) begin n_bad++; $display("FAIL ignore_addr got=%h exp=0102", mem_addr); end
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL ignore_req got=%b exp=1", mem_req); end
    hcount = 10'd799;
    tick();
    n_cmp++; if (fetch_miss !== 1'b1) begin n_bad++; $display("FAIL ignore_abort_miss got=%b exp=1", fetch_miss); end
    hcount = 10'd0;
    tick();
  endtask

  task automatic test_late_grant();
    gnt_delay = 5;
    run_line(95);
    n_cmp++; if (first_addr !== 16'h0104) begin n_bad++; $display("FAIL late_addr got=%h exp=0104", first_addr); end
    n_cmp++; if (req_cycles !== 6) begin n_bad++; $display("FAIL late_req_cycles got=%0d exp=6", req_cycles); end
    n_cmp++; if (currLine !== 16'h5A04) begin n_bad++; $display("FAIL late_currLine got=%h exp=5A04", currLine); end
    n_cmp++; if (miss_cycles !== 0) begin n_bad++; $display("FAIL late_miss got=%0d exp=0", miss_cycles); end
  endtask

  task automatic test_reset_in_data();
    int miss = 0;
    gnt_delay = 0;
    vcount = 10'd47;
    for (int h = 640; h <= 651; h++) begin
      hcount = 10'(h);
      tick();
    end
    // The FSM is now in DATA. Reset applies on the next edge.
    reset  = 1'b1;
    hcount = 10'd652;
    tick();
    reset  = 1'b0;
    n_cmp++; if (currLine !== 16'h0000) begin n_bad++; $display("FAIL rstdata_currLine got=%h exp=0000", currLine); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rstdata_req got=%b exp=0", mem_req); end
    n_cmp++; if (mem_addr !== 16'h0000) begin n_bad++; $display("FAIL rstdata_addr got=%h exp=0000", mem_addr); end
    n_cmp++; if (fetch_miss !== 1'b0) begin n_bad++; $display("FAIL rstdata_miss got=%b exp=0", fetch_miss); end
    for (int h = 653; h <= 800; h++) begin
      hcount = (h <= 799) ? 10'(h) : 10'd0;
      tick();
      if (fetch_miss) miss++;
    end
    n_cmp++; if (miss !== 0) begin n_bad++; $display("FAIL rstdata_no_pulse got=%0d exp=0", miss); end
    n_cmp++; if (currLine !== 16'h0000) begin n_bad++; $display("FAIL rstdata_swap got=%h exp=0000", currLine); end
    run_line(95);
    n_cmp++; if (first_addr !== 16'h0104) begin n_bad++; $display("FAIL postrst_addr got=%h exp=0104", first_addr); end
    n_cmp++; if (currLine !== 16'h5A04) begin n_bad++; $display("FAIL postrst_currLine got=%h exp=5A04", currLine); end
    n_cmp++; if (miss_cycles !== 0) begin n_bad++; $display("FAIL postrst_miss got=%0d exp=0", miss_cycles); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h5A00 | 16'(i);
    mem[8'h00] = 16'h03FF;
    mem[8'h02] = 16'h03F1;
    reset     = 1'b1;
    hcount    = 10'd0;
    vcount    = 10'd0;
    mem_gnt   = 1'b0;
    mem_data  = 16'h0000;
    gnt_delay = 0;
    req_cnt   = 0;

    test_reset();
    test_fetch_basic();
    test_rows();
    test_blank();
    test_miss();
    test_ignore_trigger();
    test_late_grant();
    test_reset_in_data();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
